// File: rtl/vga_pkg.sv
// Shared timing defaults, counter type and lock-state enum for the
// VGA porch stage.
package vga_pkg;

  localparam int TOTAL_COLS_DEF    = 800;
  localparam int TOTAL_ROWS_DEF    = 525;
  localparam int ACTIVE_COLS_DEF   = 640;
  localparam int ACTIVE_ROWS_DEF   = 480;
  localparam int FRONT_PORCH_H_DEF = 16;
  localparam int BACK_PORCH_H_DEF  = 48;
  localparam int FRONT_PORCH_V_DEF = 10;
  localparam int BACK_PORCH_V_DEF  = 33;
  localparam int VIDEO_WIDTH_DEF   = 3;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  function automatic logic in_range(
    input cnt_t v,
    input cnt_t lo,
    input cnt_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_porch_if.sv
// Raw or porch-adjusted sync plus RGB video bundle; the producer
// takes master, the consumer takes slave.
interface vga_sync_porch_if #(
  parameter int VIDEO_WIDTH = vga_pkg::VIDEO_WIDTH_DEF
);

  logic                   HSync;
  logic                   VSync;
  logic [VIDEO_WIDTH-1:0] Red_Video;
  logic [VIDEO_WIDTH-1:0] Grn_Video;
  logic [VIDEO_WIDTH-1:0] Blu_Video;

  modport master (
    output HSync,
    output VSync,
    output Red_Video,
    output Grn_Video,
    output Blu_Video
  );

  modport slave (
    input HSync,
    input VSync,
    input Red_Video,
    input Grn_Video,
    input Blu_Video
  );

endinterface

// File: rtl/vga_sync_to_count.sv
// Frame-start edge detect and free-running col/row counters that
// reload on every frame start; flags frame starts that arrive early.
module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS = TOTAL_COLS_DEF,
  parameter int TOTAL_ROWS = TOTAL_ROWS_DEF
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_VSync,
  output logic o_FS,
  output logic o_OffSched,
  output cnt_t o_Col,
  output cnt_t o_Row
);

  localparam cnt_t COL_END = cnt_t'(TOTAL_COLS - 1);
  localparam cnt_t ROW_END = cnt_t'(TOTAL_ROWS - 1);

  logic r_VSync_d;
  cnt_t r_Col;
  cnt_t r_Row;

  logic w_FS;
  logic w_ColEnd;
  logic w_RowEnd;

  assign w_FS     = i_VSync & ~r_VSync_d;
  assign w_ColEnd = (r_Col == COL_END);
  assign w_RowEnd = (r_Row == ROW_END);

  // A start is on schedule only if the previous pixel closed the frame.
  assign o_OffSched = w_FS & ~(w_ColEnd & w_RowEnd);
  assign o_FS       = w_FS;
  assign o_Col      = r_Col;
  assign o_Row      = r_Row;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_VSync_d <= 1'b0;
      r_Col     <= '0;
      r_Row     <= '0;
    end else begin
      r_VSync_d <= i_VSync;
      if (w_FS) begin
        r_Col <= '0;
        r_Row <= '0;
      end else if (w_ColEnd) begin
        r_Col <= '0;
        r_Row <= w_RowEnd ? '0 : r_Row + CNT_ONE;
      end else begin
        r_Col <= r_Col + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/vga_sync_porch.sv
// Re-times raw VGA sync into active-low pulses with porches, two-clock
// video delay. VGA_PORCH_BLANK_EN zeroes video outside the active area.
module vga_sync_porch
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS    = TOTAL_COLS_DEF,
  parameter int TOTAL_ROWS    = TOTAL_ROWS_DEF,
  parameter int ACTIVE_COLS   = ACTIVE_COLS_DEF,
  parameter int ACTIVE_ROWS   = ACTIVE_ROWS_DEF,
  parameter int FRONT_PORCH_H = FRONT_PORCH_H_DEF,
  parameter int BACK_PORCH_H  = BACK_PORCH_H_DEF,
  parameter int FRONT_PORCH_V = FRONT_PORCH_V_DEF,
  parameter int BACK_PORCH_V  = BACK_PORCH_V_DEF,
  parameter int VIDEO_WIDTH   = VIDEO_WIDTH_DEF
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  vga_sync_porch_if.slave  i_Vid,
  vga_sync_porch_if.master o_Vid,
  output logic            o_Locked,
  output logic            o_Resync
);

  localparam cnt_t HS_LO =
    cnt_t'(ACTIVE_COLS + FRONT_PORCH_H);
  localparam cnt_t HS_HI =
    cnt_t'(TOTAL_COLS - BACK_PORCH_H - 1);
  localparam cnt_t VS_LO =
    cnt_t'(ACTIVE_ROWS + FRONT_PORCH_V);
  localparam cnt_t VS_HI =
    cnt_t'(TOTAL_ROWS - BACK_PORCH_V - 1);

`ifdef VGA_PORCH_BLANK_EN
  localparam cnt_t H_ACT = cnt_t'(ACTIVE_COLS);
  localparam cnt_t V_ACT = cnt_t'(ACTIVE_ROWS);
`endif

  lock_state_e r_State;
  lock_state_e w_State_Next;

  logic w_FS;
  logic w_OffSched;
  cnt_t w_Col;
  cnt_t w_Row;

  logic [VIDEO_WIDTH-1:0] r_Red1;
  logic [VIDEO_WIDTH-1:0] r_Grn1;
  logic [VIDEO_WIDTH-1:0] r_Blu1;
  logic                   r_Resync1;

  logic                   w_Live;
  logic                   w_HSync;
  logic                   w_VSync;
  logic [VIDEO_WIDTH-1:0] w_Red;
  logic [VIDEO_WIDTH-1:0] w_Grn;
  logic [VIDEO_WIDTH-1:0] w_Blu;

  // Raw HSync carries no timing here; counters run from frame start.
  logic w_unused_hsync;
  assign w_unused_hsync = i_Vid.HSync;

  vga_sync_to_count #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_count (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_VSync    (i_Vid.VSync),
    .o_FS       (w_FS),
    .o_OffSched (w_OffSched),
    .o_Col      (w_Col),
    .o_Row      (w_Row)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State <= UNLOCKED;
    end else begin
      r_State <= w_State_Next;
    end
  end

  always_comb begin
    w_State_Next = r_State;
    unique case (r_State)
      UNLOCKED: if (w_FS) w_State_Next = LOCKED;
      LOCKED:   w_State_Next = LOCKED;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Red1    <= '0;
      r_Grn1    <= '0;
      r_Blu1    <= '0;
      r_Resync1 <= 1'b0;
    end else begin
      r_Red1    <= i_Vid.Red_Video;
      r_Grn1    <= i_Vid.Grn_Video;
      r_Blu1    <= i_Vid.Blu_Video;
      r_Resync1 <= w_OffSched & (r_State == LOCKED);
    end
  end

  // r_State advances with stage 1, so it already describes w_Col/w_Row.
  assign w_Live = (r_State == LOCKED);

  always_comb begin
    w_HSync = 1'b1;
    w_VSync = 1'b1;
    w_Red   = '0;
    w_Grn   = '0;
    w_Blu   = '0;
    if (w_Live) begin
      w_HSync = ~in_range(w_Col, HS_LO, HS_HI);
      w_VSync = ~in_range(w_Row, VS_LO, VS_HI);
      w_Red   = r_Red1;
      w_Grn   = r_Grn1;
      w_Blu   = r_Blu1;
`ifdef VGA_PORCH_BLANK_EN
      if ((w_Col >= H_ACT) || (w_Row >= V_ACT)) begin
        w_Red = '0;
        w_Grn = '0;
        w_Blu = '0;
      end
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Vid.HSync     <= 1'b1;
      o_Vid.VSync     <= 1'b1;
      o_Vid.Red_Video <= '0;
      o_Vid.Grn_Video <= '0;
      o_Vid.Blu_Video <= '0;
      o_Locked        <= 1'b0;
      o_Resync        <= 1'b0;
    end else begin
      o_Vid.HSync     <= w_HSync;
      o_Vid.VSync     <= w_VSync;
      o_Vid.Red_Video <= w_Red;
      o_Vid.Grn_Video <= w_Grn;
      o_Vid.Blu_Video <= w_Blu;
      o_Locked        <= w_Live;
      o_Resync        <= r_Resync1 & w_Live;
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Scoreboard bench: a full-size and a shrunk-geometry instance driven
// by their own generators and checked every pixel against a model.
module tb_vga_sync_porch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_sync_porch_if #(.VIDEO_WIDTH(3)) in0 ();
  vga_sync_porch_if #(.VIDEO_WIDTH(3)) out0 ();
  vga_sync_porch_if #(.VIDEO_WIDTH(3)) in1 ();
  vga_sync_porch_if #(.VIDEO_WIDTH(3)) out1 ();

  logic lk0, rs0, lk1, rs1;

  logic       vs_d  [2];
  logic       hs_d  [2];
  logic [8:0] vid_d [2];

  assign in0.VSync     = vs_d[0];
  assign in0.HSync     = hs_d[0];
  assign in0.Red_Video = vid_d[0][8:6];
  assign in0.Grn_Video = vid_d[0][5:3];
  assign in0.Blu_Video = vid_d[0][2:0];
  assign in1.VSync     = vs_d[1];
  assign in1.HSync     = hs_d[1];
  assign in1.Red_Video = vid_d[1][8:6];
  assign in1.Grn_Video = vid_d[1][5:3];
  assign in1.Blu_Video = vid_d[1][2:0];

  wire [12:0] obs0 = {out0.HSync, out0.VSync, out0.Red_Video,
                      out0.Grn_Video, out0.Blu_Video, lk0, rs0};
  wire [12:0] obs1 = {out1.HSync, out1.VSync, out1.Red_Video,
                      out1.Grn_Video, out1.Blu_Video, lk1, rs1};

  vga_sync_porch u_full (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Vid    (in0),
    .o_Vid    (out0),
    .o_Locked (lk0),
    .o_Resync (rs0)
  );

  vga_sync_porch #(
    .TOTAL_COLS    (80),
    .TOTAL_ROWS    (30),
    .ACTIVE_COLS   (64),
    .ACTIVE_ROWS   (20),
    .FRONT_PORCH_H (4),
    .BACK_PORCH_H  (8),
    .FRONT_PORCH_V (2),
    .BACK_PORCH_V  (6),
    .VIDEO_WIDTH   (3)
  ) u_small (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Vid    (in1),
    .o_Vid    (out1),
    .o_Locked (lk1),
    .o_Resync (rs1)
  );

  int TC  [2] = '{800, 80};
  int TR  [2] = '{525, 30};
  int AC  [2] = '{640, 64};
  int AR  [2] = '{480, 20};
  int FPH [2] = '{16, 4};
  int BPH [2] = '{48, 8};
  int FPV [2] = '{10, 2};
  int BPV [2] = '{33, 6};

  localparam logic [12:0] RST_OUT = 13'h1800;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] q0 [$];
  logic [12:0] q1 [$];

  int m_col [2];
  int m_row [2];
  bit m_prev [2];
  bit m_lock [2];

  int g_col [2];
  int g_row [2];
  int gs [2];
  bit run [2];
  bit first [2];
  int tgt_c [2] = '{100, 40};
  int tgt_r [2] = '{7, 10};

  int hs_low [2];
  int vs_low [2];
  int rs_cnt [2];
  int lk_hi [2];
  int lk_lo [2];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] expect_out(
    input int         k,
    input bit         live,
    input int         col,
    input int         row,
    input logic [8:0] vid,
    input bit         rsy
  );
    bit hs;
    bit vs;
    logic [8:0] v;
    if (!live) return RST_OUT;
    hs = !(col >= AC[k] + FPH[k] && col <= TC[k] - BPH[k] - 1);
    vs = !(row >= AR[k] + FPV[k] && row <= TR[k] - BPV[k] - 1);
    v  = vid;
`ifdef VGA_PORCH_BLANK_EN
    if (col >= AC[k] || row >= AR[k]) v = '0;
`endif
    return {hs, vs, v, 1'b1, rsy};
  endfunction

  task automatic push(input int k, input logic [12:0] e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic rst_model(input int k);
    m_col[k]  = 0;
    m_row[k]  = 0;
    m_prev[k] = 1'b0;
    m_lock[k] = 1'b0;
    vs_d[k]   = 1'b0;
    hs_d[k]   = 1'b0;
    vid_d[k]  = '0;
    // the pixel already in stage 1 is wiped by this reset edge
    if (k == 0) begin
      if (q0.size() > 0) q0[q0.size()-1] = RST_OUT;
    end else begin
      if (q1.size() > 0) q1[q1.size()-1] = RST_OUT;
    end
    push(k, RST_OUT);
  endtask

  task automatic drive(input int k);
    logic vs;
    logic hs;
    logic [8:0] vid;
    bit fs;
    bit offs;
    if (gs[k] == 2) begin
      g_col[k] = 0;
      g_row[k] = 0;
      gs[k] = 3;
    end
    vs = run[k] && (g_row[k] < AR[k]);
    hs = run[k] && (g_col[k] < AC[k]);
    if (gs[k] == 1 && g_col[k] == tgt_c[k] - 1 &&
        g_row[k] == tgt_r[k]) begin
      vs = 1'b0;
      gs[k] = 2;
    end
    if (!run[k] || (vs && hs)) vid = 9'($urandom);
    else vid = 9'h1FF;
    if (first[k] && vs) begin
      vid[8:6] = 3'd5;
      first[k] = 1'b0;
    end
    vs_d[k]  = vs;
    hs_d[k]  = hs;
    vid_d[k] = vid;
    fs   = vs && !m_prev[k];
    offs = 1'b0;
    if (fs) begin
      offs = m_lock[k] &&
             !(m_col[k] == TC[k] - 1 && m_row[k] == TR[k] - 1);
      m_col[k]  = 0;
      m_row[k]  = 0;
      m_lock[k] = 1'b1;
    end else if (m_col[k] == TC[k] - 1) begin
      m_col[k] = 0;
      m_row[k] = (m_row[k] == TR[k] - 1) ? 0 : m_row[k] + 1;
    end else begin
      m_col[k]++;
    end
    m_prev[k] = vs;
    push(k, expect_out(k, m_lock[k], m_col[k], m_row[k], vid, offs));
    if (run[k]) begin
      if (g_col[k] == TC[k] - 1) begin
        g_col[k] = 0;
        g_row[k] = (g_row[k] == TR[k] - 1) ? 0 : g_row[k] + 1;
      end else begin
        g_col[k]++;
      end
    end
  endtask

  task automatic tally(input int k, input logic [12:0] o);
    if (!o[12]) hs_low[k]++;
    if (!o[11]) vs_low[k]++;
    if (o[0]) rs_cnt[k]++;
    if (o[1]) lk_hi[k]++;
    else lk_lo[k]++;
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      hs_low[k] = 0;
      vs_low[k] = 0;
      rs_cnt[k] = 0;
      lk_hi[k]  = 0;
      lk_lo[k]  = 0;
    end
  endtask

  task automatic step(input bit r);
    logic [12:0] e;
    @(negedge clk);
    if (q0.size() >= 2) begin
      e = q0.pop_front();
      check("out_full", 32'(obs0), 32'(e));
    end
    if (q1.size() >= 2) begin
      e = q1.pop_front();
      check("out_small", 32'(obs1), 32'(e));
    end
    tally(0, obs0);
    tally(1, obs1);
    rst = r;
    if (r) begin
      rst_model(0);
      rst_model(1);
    end else begin
      drive(0);
      drive(1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      run[k] = 1'b0;
      gs[k] = 0;
      first[k] = 1'b0;
      g_col[k] = 0;
      g_row[k] = 0;
    end
    clr();
    repeat (5) step(1'b1);
    repeat (20) step(1'b0);
    check("idle_lock_full", 32'(lk_hi[0]), 32'd0);
    check("idle_lock_small", 32'(lk_hi[1]), 32'd0);

    clr();
    for (int k = 0; k < 2; k++) begin
      run[k] = 1'b1;
      first[k] = 1'b1;
    end
    repeat (4800) step(1'b0);
    check("hs_low_full", 32'(hs_low[0]), 32'd576);
    check("hs_low_small", 32'(hs_low[1]), 32'd240);
    check("vs_low_full", 32'(vs_low[0]), 32'd0);
    check("vs_low_small", 32'(vs_low[1]), 32'd320);
    check("rsy_frames_full", 32'(rs_cnt[0]), 32'd0);
    check("rsy_frames_small", 32'(rs_cnt[1]), 32'd0);

    clr();
    gs[0] = 1;
    gs[1] = 1;
    for (int i = 0; i < 5000; i++) begin
      if (gs[0] == 3 && gs[1] == 3) break;
      step(1'b0);
    end
    check("glitch_bound", 32'(gs[0] == 3 && gs[1] == 3), 32'd1);
    repeat (50) step(1'b0);
    check("rsy_once_full", 32'(rs_cnt[0]), 32'd1);
    check("rsy_once_small", 32'(rs_cnt[1]), 32'd1);
    check("stay_lock_full", 32'(lk_lo[0]), 32'd0);
    check("stay_lock_small", 32'(lk_lo[1]), 32'd0);

    repeat (100) step(1'b0);
    clr();
    step(1'b1);
    for (int k = 0; k < 2; k++) begin
      g_row[k] = TR[k] - 1;
      g_col[k] = TC[k] - 4;
    end
    repeat (300) step(1'b0);
    check("unlock_seen_full", 32'(lk_lo[0] != 0), 32'd1);
    check("unlock_seen_small", 32'(lk_lo[1] != 0), 32'd1);
    check("relock_rsy_full", 32'(rs_cnt[0]), 32'd0);
    check("relock_rsy_small", 32'(rs_cnt[1]), 32'd0);
    check("relock_full", 32'(lk0), 32'd1);
    check("relock_small", 32'(lk1), 32'd1);
    repeat (2) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
